// File: rtl/sram_evict_rd_ctrl_pkg.sv
// Shared vector-cache types for the evict read controller: SRAM instance
// command layout, evict beat count and evict FSM state encoding.
package vector_cache_pkg;

  localparam int unsigned ADDR_W      = 9;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned EVICT_BEATS = 4;
  localparam int unsigned BEAT_W      = 2;
  localparam int unsigned LINE_W      = DATA_W * EVICT_BEATS;
  localparam int unsigned OPC_W       = 3;
  localparam int unsigned MODE_W      = 2;
  localparam int unsigned BSEL_W      = 4;

  localparam logic [OPC_W-1:0] OPC_EVICT = OPC_W'(1);

  typedef enum logic [1:0] {
    EV_IDLE = 2'd0,
    EV_READ = 2'd1,
    EV_WAIT = 2'd2,
    EV_OUT  = 2'd3
  } evict_state_e;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [MODE_W-1:0] mode;
    logic [BSEL_W-1:0] byte_sel;
    logic [BEAT_W-1:0] req_num;
    logic [ADDR_W-1:0] addr;
  } sram_inst_cmd_t;

endpackage

// File: rtl/sram_evict_rd_ctrl_if.sv
// Evict read controller bus bundle: evict request in, SRAM read command out,
// SRAM read data in, assembled line out.
//   slave  : controller side (the design)
//   master : requester / SRAM / line consumer side
interface sram_evict_rd_ctrl_if
  import vector_cache_pkg::*;
#(
  parameter int unsigned ID_W = 4
);

  logic                  evict_req_vld;
  logic                  evict_req_rdy;
  logic [ADDR_W-1:0]     evict_addr;
  logic [ID_W-1:0]       evict_id;
  logic                  sram_wr_busy;
  logic                  sram_read_vld;
  sram_inst_cmd_t        sram_read_cmd;
  logic [DATA_W-1:0]     sram_rd_data;
  logic                  line_vld;
  logic                  line_rdy;
  logic [LINE_W-1:0]     line_data;
  logic [ID_W-1:0]       line_id;

  modport slave (
    input  evict_req_vld, evict_addr, evict_id, sram_wr_busy, sram_rd_data, line_rdy,
    output evict_req_rdy, sram_read_vld, sram_read_cmd, line_vld, line_data, line_id
  );

  modport master (
    output evict_req_vld, evict_addr, evict_id, sram_wr_busy, sram_rd_data, line_rdy,
    input  evict_req_rdy, sram_read_vld, sram_read_cmd, line_vld, line_data, line_id
  );

endinterface

// File: rtl/sram_evict_rd_ctrl.sv
// Evict read controller: accepts one evict request at a time, reads the
// four 32-bit beats of the line from the SRAM (yielding to the write port
// whenever it is busy), assembles them into a 128-bit line and hands the
// line plus its request tag to the consumer with a valid/ready handshake.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sram_evict_rd_ctrl_if.slave (request, SRAM command/data, line)
module sram_evict_rd_ctrl
  import vector_cache_pkg::*;
#(
  parameter int unsigned ID_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sram_evict_rd_ctrl_if.slave  bus
);

  evict_state_e        state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                cap_vld_q, cap_vld_d;
  logic [BEAT_W-1:0]   cap_idx_q, cap_idx_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                issue_c;

  // A beat issues only in READ and only when the write port leaves the SRAM free.
  assign issue_c = (state_q == EV_READ) && !bus.sram_wr_busy;

  // Next-state, beat counter and line capture.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    id_d      = id_q;
    cap_vld_d = issue_c;
    cap_idx_d = beat_q;
    line_d    = line_q;

    // Read data lands one cycle after its issue; write it to the lane it was read for.
    if (cap_vld_q) begin
      line_d[{cap_idx_q, 5'd0} +: DATA_W] = bus.sram_rd_data;
    end

    unique case (state_q)
      EV_IDLE: begin
        if (bus.evict_req_vld) begin
          addr_d  = bus.evict_addr;
          id_d    = bus.evict_id;
          beat_d  = '0;
          state_d = EV_READ;
        end
      end
      EV_READ: begin
        if (issue_c) begin
          beat_d = BEAT_W'(beat_q + BEAT_W'(1));
          if (beat_q == BEAT_W'(EVICT_BEATS - 1)) begin
            state_d = EV_WAIT;
          end
        end
      end
      // One cycle for the last beat's data to be captured.
      EV_WAIT: begin
        state_d = EV_OUT;
      end
      EV_OUT: begin
        if (bus.line_rdy) begin
          state_d = EV_IDLE;
        end
      end
      default: begin
        state_d = EV_IDLE;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EV_IDLE;
      beat_q    <= '0;
      addr_q    <= '0;
      id_q      <= '0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
      line_q    <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      id_q      <= id_d;
      cap_vld_q <= cap_vld_d;
      cap_idx_q <= cap_idx_d;
      line_q    <= line_d;
    end
  end

  // Handshake and line outputs are decoded straight from registered state.
  assign bus.evict_req_rdy = (state_q == EV_IDLE);
  assign bus.line_vld      = (state_q == EV_OUT);
  assign bus.line_data     = line_q;
  assign bus.line_id       = id_q;

  // The read strobe must react to the write port in the same cycle.
  assign bus.sram_read_vld = issue_c;

  // Command fields are zero whenever no read is issued.
  always_comb begin
    bus.sram_read_cmd = '0;
    if (issue_c) begin
      bus.sram_read_cmd.opcode   = OPC_EVICT;
      bus.sram_read_cmd.mode     = '0;
      bus.sram_read_cmd.byte_sel = '0;
      bus.sram_read_cmd.req_num  = beat_q;
      bus.sram_read_cmd.addr     = addr_q;
    end
  end

  a_no_read_while_busy: assert property (
    @(posedge clk) disable iff (!rst_n) !(bus.sram_read_vld && bus.sram_wr_busy)
  );

endmodule
